// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length/payload/checksum frame, writes
// 32-bit words to instruction memory and holds the core in reset until a valid image lands.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        core_hold,
  output logic        done,
  output logic        err_len,
  output logic        err_sum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        core_hold_q, core_hold_d;
  logic        done_q, done_d;
  logic        err_len_q, err_len_d;
  logic        err_sum_q, err_sum_d;

  logic        xfer;
  logic [15:0] hdr_count;
  logic [15:0] next_word_cnt;

  assign xfer          = in_valid && in_ready_q;
  assign hdr_count     = {in_data, len_lo_q};
  assign next_word_cnt = word_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    len_lo_d    = len_lo_q;
    count_d     = count_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_buf_d  = word_buf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    err_len_d   = err_len_q;
    err_sum_d   = err_sum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_LEN0;
          sum_d      = 8'd0;
          count_d    = 16'd0;
          word_cnt_d = 16'd0;
          byte_idx_d = 2'd0;
          err_len_d  = 1'b0;
          err_sum_d  = 1'b0;
        end
      end

      S_LEN0: begin
        if (xfer) begin
          len_lo_d = in_data;
          sum_d    = sum_q + in_data;
          state_d  = S_LEN1;
        end
      end

      S_LEN1: begin
        if (xfer) begin
          count_d    = hdr_count;
          sum_d      = sum_q + in_data;
          byte_idx_d = 2'd0;
          if ({16'd0, hdr_count} > MAX_WORDS) begin
            state_d   = S_ERROR;
            err_len_d = 1'b1;
          end else if (hdr_count == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          sum_d      = sum_q + in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word; the write is registered for next cycle
              mem_we_d   = 1'b1;
              mem_wd_d   = {in_data, word_buf_q};
              mem_addr_d = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
              word_cnt_d = next_word_cnt;
              if (next_word_cnt == count_q) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end

      S_CHECK: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_ERROR;
            err_sum_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies
    in_ready_d  = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                  (state_d == S_DATA) || (state_d == S_CHECK);
    core_hold_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sum_q       <= 8'd0;
      len_lo_q    <= 8'd0;
      count_q     <= 16'd0;
      word_cnt_q  <= 16'd0;
      byte_idx_q  <= 2'd0;
      word_buf_q  <= 24'd0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wd_q    <= 32'd0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_sum_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      len_lo_q    <= len_lo_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_buf_q  <= word_buf_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
      err_sum_q   <= err_sum_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign err_len   = err_len_q;
  assign err_sum   = err_sum_q;

endmodule
